ri5cy_ahb_bridge: RTL and testbench

RI5CY_AHB_BRIDGE -- requirements
Module: ri5cy_ahb_bridge

---
 rtl/ri5cy_ahb_bridge_if.sv | 47 ++++
 rtl/ri5cy_ahb_bridge.sv | 140 ++++++++++++++
 tb/tb_ri5cy_ahb_bridge.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ri5cy_ahb_bridge_if.sv
// Bundle of core request/response and AHB-Lite master signals
// for the RI5CY data-port to AHB bridge.
interface ri5cy_ahb_bridge_if #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
);
    logic                      req_i;
    logic                      we_i;
    logic [3:0]                be_i;
    logic [31:0]               addr_i;
    logic [31:0]               wdata_i;
    logic                      gnt_o;
    logic                      rvalid_o;
    logic                      err_o;
    logic [31:0]               rdata_o;
    logic                      hsel_o;
    logic                      hwrite_o;
    logic                      hmastlock_o;
    logic                      hready_o;
    logic [AHB_ADDR_WIDTH-1:0] haddr_o;
    logic [AHB_DATA_WIDTH-1:0] hwdata_o;
    logic [2:0]                hsize_o;
    logic [2:0]                hburst_o;
    logic [3:0]                hprot_o;
    logic [1:0]                htrans_o;
    logic [AHB_DATA_WIDTH-1:0] hrdata_i;
    logic                      hreadyout_i;
    logic                      hresp_i;

    modport master (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, err_o, rdata_o,
        output hsel_o, hwrite_o, hmastlock_o, hready_o,
        output haddr_o, hwdata_o, hsize_o, hburst_o,
        output hprot_o, htrans_o,
        input  hrdata_i, hreadyout_i, hresp_i
    );

    modport slave (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, err_o, rdata_o,
        input  hsel_o, hwrite_o, hmastlock_o, hready_o,
        input  haddr_o, hwdata_o, hsize_o, hburst_o,
        input  hprot_o, htrans_o,
        output hrdata_i, hreadyout_i, hresp_i
    );
endinterface

// File: rtl/ri5cy_ahb_bridge.sv
// RI5CY core data port to AHB-Lite master bridge.
// Single outstanding transfer, pipelined address/data phases.
module ri5cy_ahb_bridge #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rstn,
    ri5cy_ahb_bridge_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_ERR1,
        S_ILL
    } state_e;

    state_e                    state_q, state_d;
    logic                      we_q, we_d;
    logic                      lane_q, lane_d;
    logic [AHB_DATA_WIDTH-1:0] hwdata_q, hwdata_d;

    logic       be_legal;
    logic [2:0] size;
    logic [1:0] offset;
    logic       data_ok;
    logic       data_err;
    logic       accept;
    logic       lane_sel;
    logic [31:0] wmask;
    logic [31:0] wdata_m;
    logic [31:0] rd_lane;
    logic       unused_addr;

    assign unused_addr = ^bus.addr_i[1:0];

    assign bus.hburst_o    = 3'b000;
    assign bus.hprot_o     = 4'b0011;
    assign bus.hmastlock_o = 1'b0;
    assign bus.hready_o    = bus.hreadyout_i;
    assign bus.hwdata_o    = hwdata_q;
    assign bus.hwrite_o    = bus.we_i;
    assign bus.hsize_o     = size;
    assign bus.haddr_o     =
        AHB_ADDR_WIDTH'({bus.addr_i[31:2], offset});

    // Byte-enable decode into transfer size and byte offset
    always_comb begin
        be_legal = 1'b1;
        size     = 3'b010;
        offset   = 2'b00;
        unique case (bus.be_i)
            4'b0001: begin size = 3'b000; offset = 2'd0; end
            4'b0010: begin size = 3'b000; offset = 2'd1; end
            4'b0100: begin size = 3'b000; offset = 2'd2; end
            4'b1000: begin size = 3'b000; offset = 2'd3; end
            4'b0011: begin size = 3'b001; offset = 2'd0; end
            4'b1100: begin size = 3'b001; offset = 2'd2; end
            4'b1111: begin size = 3'b010; offset = 2'd0; end
            default: be_legal = 1'b0;
        endcase
    end

    // Handshake, response and write-lane steering
    always_comb begin
        data_ok  = (state_q == S_DATA) && bus.hreadyout_i
                   && !bus.hresp_i;
        data_err = (state_q == S_DATA) && bus.hresp_i;
        accept   = rstn && bus.req_i && bus.hreadyout_i
                   && ((state_q == S_IDLE) || data_ok);

        bus.gnt_o    = accept;
        bus.htrans_o = (accept && be_legal) ? 2'b10 : 2'b00;
        bus.hsel_o   = accept && be_legal;

        bus.rvalid_o = rstn && (data_ok
                       || (data_err && bus.hreadyout_i)
                       || ((state_q == S_ERR1) && bus.hresp_i
                           && bus.hreadyout_i)
                       || (state_q == S_ILL));
        bus.err_o    = bus.rvalid_o && !data_ok;

        rd_lane     = lane_q ? bus.hrdata_i[AHB_DATA_WIDTH-1 -: 32]
                             : bus.hrdata_i[31:0];
        bus.rdata_o = (data_ok && !we_q) ? rd_lane : 32'h0;

        lane_sel = (AHB_DATA_WIDTH == 64) ? bus.addr_i[2] : 1'b0;
        wmask    = {{8{bus.be_i[3]}}, {8{bus.be_i[2]}},
                    {8{bus.be_i[1]}}, {8{bus.be_i[0]}}};
        wdata_m  = bus.wdata_i & wmask;
    end

    // Next state and next transfer attributes
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        lane_d   = lane_q;
        hwdata_d = hwdata_q;
        unique case (state_q)
            S_IDLE: ;
            S_DATA: begin
                if (bus.hresp_i)
                    state_d = bus.hreadyout_i ? S_IDLE : S_ERR1;
                else if (bus.hreadyout_i)
                    state_d = S_IDLE;
            end
            S_ERR1: begin
                if (bus.hresp_i && bus.hreadyout_i)
                    state_d = S_IDLE;
            end
            S_ILL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d  = be_legal ? S_DATA : S_ILL;
            we_d     = bus.we_i;
            lane_d   = lane_sel;
            hwdata_d = '0;
            if (lane_sel)
                hwdata_d[AHB_DATA_WIDTH-1 -: 32] = wdata_m;
            else
                hwdata_d[31:0] = wdata_m;
        end
    end

    // State and data-phase registers, synchronous reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            lane_q   <= 1'b0;
            hwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            lane_q   <= lane_d;
            hwdata_q <= hwdata_d;
        end
    end
endmodule

// File: tb/tb_ri5cy_ahb_bridge.sv
// Directed self-checking bench for ri5cy_ahb_bridge,
// 32-bit and 64-bit data width instances.
module tb_ri5cy_ahb_bridge;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ri5cy_ahb_bridge_if #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32)) b();
    ri5cy_ahb_bridge_if #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(64)) w();

    ri5cy_ahb_bridge #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32)) u_dut32 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b.master)
    );

    ri5cy_ahb_bridge #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(64)) u_dut64 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (w.master)
    );

    task automatic idle_inputs();
        b.req_i = 0; b.we_i = 0; b.be_i = 4'hF; b.addr_i = 0;
        b.wdata_i = 0; b.hrdata_i = 0; b.hreadyout_i = 1; b.hresp_i = 0;
        w.req_i = 0; w.we_i = 0; w.be_i = 4'hF; w.addr_i = 0;
        w.wdata_i = 0; w.hrdata_i = 0; w.hreadyout_i = 1; w.hresp_i = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rstn = 0;
        b.req_i = 1; b.addr_i = 32'h40;
        #1;
        n_cmp++;
        if ({b.gnt_o, b.rvalid_o, b.err_o, b.hsel_o} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b want 0000",
                     {b.gnt_o, b.rvalid_o, b.err_o, b.hsel_o});
        end
        n_cmp++;
        if (b.htrans_o !== 2'b00) begin
            n_bad++; $display("FAIL reset_htrans got %b want 00", b.htrans_o);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (b.hwdata_o !== 32'h0 || w.hwdata_o !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_hwdata got %h/%h want 0", b.hwdata_o, w.hwdata_o);
        end
        @(negedge clk);
        b.req_i = 0;
        rstn = 1;
    endtask

    task automatic test_read();
        @(negedge clk);
        b.req_i = 1; b.we_i = 0; b.be_i = 4'hF; b.addr_i = 32'h1000;
        #1;
        n_cmp++;
        if (b.gnt_o !== 1 || b.htrans_o !== 2'b10 || b.hsel_o !== 1) begin
            n_bad++;
            $display("FAIL read_addr_phase got gnt=%b htrans=%b hsel=%b want 1 10 1",
                     b.gnt_o, b.htrans_o, b.hsel_o);
        end
        n_cmp++;
        if (b.haddr_o !== 32'h1000 || b.hsize_o !== 3'b010) begin
            n_bad++;
            $display("FAIL read_haddr got %h size %b want 00001000 010",
                     b.haddr_o, b.hsize_o);
        end
        n_cmp++;
        if (b.hburst_o !== 3'b000 || b.hprot_o !== 4'b0011
            || b.hmastlock_o !== 0 || b.hready_o !== 1) begin
            n_bad++;
            $display("FAIL read_ties got %b %b %b %b want 000 0011 0 1",
                     b.hburst_o, b.hprot_o, b.hmastlock_o, b.hready_o);
        end
        @(negedge clk);
        b.req_i = 0; b.hrdata_i = 32'h1234_5678;
        #1;
        n_cmp++;
        if (b.rvalid_o !== 1 || b.err_o !== 0 || b.rdata_o !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL read_resp got v=%b e=%b d=%h want 1 0 12345678",
                     b.rvalid_o, b.err_o, b.rdata_o);
        end
    endtask

    task automatic test_write();
        @(negedge clk);
        b.req_i = 1; b.we_i = 1; b.be_i = 4'b0100;
        b.addr_i = 32'h3000; b.wdata_i = 32'hAABB_CCDD;
        #1;
        n_cmp++;
        if (b.gnt_o !== 1 || b.haddr_o !== 32'h3002 || b.hsize_o !== 3'b000
            || b.hwrite_o !== 1) begin
            n_bad++;
            $display("FAIL write_addr got gnt=%b a=%h s=%b w=%b want 1 00003002 000 1",
                     b.gnt_o, b.haddr_o, b.hsize_o, b.hwrite_o);
        end
        @(negedge clk);
        b.req_i = 0; b.we_i = 0; b.hrdata_i = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (b.hwdata_o !== 32'h00BB_0000) begin
            n_bad++; $display("FAIL write_hwdata got %h want 00bb0000", b.hwdata_o);
        end
        n_cmp++;
        if (b.rvalid_o !== 1 || b.err_o !== 0 || b.rdata_o !== 32'h0) begin
            n_bad++;
            $display("FAIL write_resp got v=%b e=%b d=%h want 1 0 0",
                     b.rvalid_o, b.err_o, b.rdata_o);
        end
        @(negedge clk);
        b.req_i = 1; b.we_i = 1; b.be_i = 4'b1100;
        b.addr_i = 32'h4000; b.wdata_i = 32'h1122_3344;
        #1;
        n_cmp++;
        if (b.haddr_o !== 32'h4002 || b.hsize_o !== 3'b001) begin
            n_bad++;
            $display("FAIL half_addr got %h %b want 00004002 001", b.haddr_o, b.hsize_o);
        end
        @(negedge clk);
        b.req_i = 0; b.we_i = 0;
        #1;
        n_cmp++;
        if (b.hwdata_o !== 32'h1122_0000 || b.rvalid_o !== 1) begin
            n_bad++;
            $display("FAIL half_data got %h v=%b want 11220000 1", b.hwdata_o, b.rvalid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic        t_req [7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [31:0] t_adr [7] = '{32'h100, 32'h104, 32'h108, 32'h108,
                                   32'h108, 32'h10C, 32'h0};
        logic        t_rdy [7] = '{1, 1, 0, 0, 1, 1, 1};
        logic [31:0] t_hrd [7] = '{32'h0, 32'hA0, 32'h0, 32'h0,
                                   32'hA1, 32'hA2, 32'hA3};
        logic        e_gnt [7] = '{1, 1, 0, 0, 1, 1, 0};
        logic        e_vld [7] = '{0, 1, 0, 0, 1, 1, 1};
        int gnts = 0;
        int vlds = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            b.req_i = t_req[i]; b.we_i = 0; b.be_i = 4'hF;
            b.addr_i = t_adr[i]; b.hreadyout_i = t_rdy[i];
            b.hrdata_i = t_hrd[i];
            #1;
            if (b.gnt_o === 1) gnts++;
            if (b.rvalid_o === 1) vlds++;
            n_cmp++;
            if (b.gnt_o !== e_gnt[i] || b.rvalid_o !== e_vld[i]) begin
                n_bad++;
                $display("FAIL b2b_c%0d got gnt=%b v=%b want %b %b",
                         i, b.gnt_o, b.rvalid_o, e_gnt[i], e_vld[i]);
            end
            if (e_vld[i]) begin
                n_cmp++;
                if (b.rdata_o !== t_hrd[i] || b.err_o !== 0) begin
                    n_bad++;
                    $display("FAIL b2b_data_c%0d got %h e=%b want %h 0",
                             i, b.rdata_o, b.err_o, t_hrd[i]);
                end
            end
            if (e_gnt[i]) begin
                n_cmp++;
                if (b.htrans_o !== 2'b10 || b.haddr_o !== t_adr[i]) begin
                    n_bad++;
                    $display("FAIL b2b_addr_c%0d got %b %h want 10 %h",
                             i, b.htrans_o, b.haddr_o, t_adr[i]);
                end
            end
        end
        n_cmp++;
        if (gnts != 4 || vlds != 4) begin
            n_bad++;
            $display("FAIL b2b_counts got gnt=%0d v=%0d want 4 4", gnts, vlds);
        end
        b.hreadyout_i = 1;
    endtask

    task automatic test_slave_error();
        @(negedge clk);
        b.req_i = 1; b.we_i = 0; b.be_i = 4'hF; b.addr_i = 32'h500;
        #1;
        n_cmp++;
        if (b.gnt_o !== 1) begin
            n_bad++; $display("FAIL err_gnt got %b want 1", b.gnt_o);
        end
        @(negedge clk);
        b.addr_i = 32'h600; b.hresp_i = 1; b.hreadyout_i = 0;
        #1;
        n_cmp++;
        if (b.htrans_o !== 2'b00 || b.gnt_o !== 0 || b.rvalid_o !== 0) begin
            n_bad++;
            $display("FAIL err_first got t=%b g=%b v=%b want 00 0 0",
                     b.htrans_o, b.gnt_o, b.rvalid_o);
        end
        @(negedge clk);
        b.hreadyout_i = 1;
        #1;
        n_cmp++;
        if (b.rvalid_o !== 1 || b.err_o !== 1 || b.rdata_o !== 0 || b.gnt_o !== 0) begin
            n_bad++;
            $display("FAIL err_second got v=%b e=%b d=%h g=%b want 1 1 0 0",
                     b.rvalid_o, b.err_o, b.rdata_o, b.gnt_o);
        end
        @(negedge clk);
        b.hresp_i = 0;
        #1;
        n_cmp++;
        if (b.gnt_o !== 1 || b.htrans_o !== 2'b10 || b.haddr_o !== 32'h600) begin
            n_bad++;
            $display("FAIL err_next got g=%b t=%b a=%h want 1 10 00000600",
                     b.gnt_o, b.htrans_o, b.haddr_o);
        end
        @(negedge clk);
        b.req_i = 0; b.hrdata_i = 32'h77;
        #1;
        n_cmp++;
        if (b.rvalid_o !== 1 || b.err_o !== 0 || b.rdata_o !== 32'h77) begin
            n_bad++;
            $display("FAIL err_after got v=%b e=%b d=%h want 1 0 77",
                     b.rvalid_o, b.err_o, b.rdata_o);
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        b.req_i = 1; b.we_i = 0; b.be_i = 4'b0101; b.addr_i = 32'h700;
        #1;
        n_cmp++;
        if (b.gnt_o !== 1 || b.htrans_o !== 2'b00 || b.hsel_o !== 0) begin
            n_bad++;
            $display("FAIL ill_accept got g=%b t=%b s=%b want 1 00 0",
                     b.gnt_o, b.htrans_o, b.hsel_o);
        end
        @(negedge clk);
        b.be_i = 4'hF;
        #1;
        n_cmp++;
        if (b.rvalid_o !== 1 || b.err_o !== 1 || b.gnt_o !== 0) begin
            n_bad++;
            $display("FAIL ill_resp got v=%b e=%b g=%b want 1 1 0",
                     b.rvalid_o, b.err_o, b.gnt_o);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (b.gnt_o !== 1 || b.htrans_o !== 2'b10) begin
            n_bad++;
            $display("FAIL ill_after got g=%b t=%b want 1 10", b.gnt_o, b.htrans_o);
        end
        @(negedge clk);
        b.req_i = 0; b.hrdata_i = 32'h55;
        #1;
        n_cmp++;
        if (b.rvalid_o !== 1 || b.err_o !== 0 || b.rdata_o !== 32'h55) begin
            n_bad++;
            $display("FAIL ill_read got v=%b e=%b d=%h want 1 0 55",
                     b.rvalid_o, b.err_o, b.rdata_o);
        end
        @(negedge clk);
        b.req_i = 1; b.be_i = 4'b0000;
        #1;
        n_cmp++;
        if (b.gnt_o !== 1 || b.htrans_o !== 2'b00) begin
            n_bad++;
            $display("FAIL ill_be0 got g=%b t=%b want 1 00", b.gnt_o, b.htrans_o);
        end
        @(negedge clk);
        b.req_i = 0; b.be_i = 4'hF;
        #1;
        n_cmp++;
        if (b.rvalid_o !== 1 || b.err_o !== 1) begin
            n_bad++;
            $display("FAIL ill_be0_resp got v=%b e=%b want 1 1", b.rvalid_o, b.err_o);
        end
    endtask

    task automatic test_wide();
        @(negedge clk);
        w.req_i = 1; w.we_i = 0; w.be_i = 4'hF; w.addr_i = 32'h2004;
        #1;
        n_cmp++;
        if (w.gnt_o !== 1 || w.haddr_o !== 32'h2004 || w.hsize_o !== 3'b010) begin
            n_bad++;
            $display("FAIL wide_addr got g=%b a=%h s=%b want 1 00002004 010",
                     w.gnt_o, w.haddr_o, w.hsize_o);
        end
        @(negedge clk);
        w.addr_i = 32'h2000; w.hrdata_i = 64'hCAFE_BABE_1234_5678;
        #1;
        n_cmp++;
        if (w.rvalid_o !== 1 || w.rdata_o !== 32'hCAFE_BABE) begin
            n_bad++;
            $display("FAIL wide_upper got v=%b d=%h want 1 cafebabe",
                     w.rvalid_o, w.rdata_o);
        end
        @(negedge clk);
        w.req_i = 0; w.hrdata_i = 64'hCAFE_BABE_1234_5678;
        #1;
        n_cmp++;
        if (w.rvalid_o !== 1 || w.rdata_o !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL wide_lower got v=%b d=%h want 1 12345678",
                     w.rvalid_o, w.rdata_o);
        end
        @(negedge clk);
        w.req_i = 1; w.we_i = 1; w.be_i = 4'b0001;
        w.addr_i = 32'h2004; w.wdata_i = 32'h1122_33EE;
        #1;
        n_cmp++;
        if (w.gnt_o !== 1 || w.hsize_o !== 3'b000 || w.haddr_o !== 32'h2004) begin
            n_bad++;
            $display("FAIL wide_wr_addr got g=%b s=%b a=%h want 1 000 00002004",
                     w.gnt_o, w.hsize_o, w.haddr_o);
        end
        @(negedge clk);
        w.req_i = 0; w.we_i = 0;
        #1;
        n_cmp++;
        if (w.hwdata_o !== 64'h0000_00EE_0000_0000 || w.rdata_o !== 0) begin
            n_bad++;
            $display("FAIL wide_wr_data got %h d=%h want 000000ee00000000 0",
                     w.hwdata_o, w.rdata_o);
        end
        @(negedge clk);
        w.req_i = 1; w.addr_i = 32'h2008;
        #1;
        n_cmp++;
        if (w.gnt_o !== 1) begin
            n_bad++; $display("FAIL wide_rst_gnt got %b want 1", w.gnt_o);
        end
        @(negedge clk);
        w.req_i = 0; rstn = 0; w.hrdata_i = 64'h99;
        #1;
        n_cmp++;
        if (w.rvalid_o !== 0 || w.gnt_o !== 0 || w.err_o !== 0) begin
            n_bad++;
            $display("FAIL wide_rst_mid got v=%b g=%b e=%b want 0 0 0",
                     w.rvalid_o, w.gnt_o, w.err_o);
        end
        @(negedge clk);
        rstn = 1;
        #1;
        n_cmp++;
        if (w.rvalid_o !== 0 || w.hwdata_o !== 64'h0) begin
            n_bad++;
            $display("FAIL wide_rst_after got v=%b hw=%h want 0 0",
                     w.rvalid_o, w.hwdata_o);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_slave_error();
        test_illegal();
        test_wide();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
